// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: request/response/redirect bundle between decode and the branch sequencer
interface branch_sequencer_if #(parameter int XLEN = 32, parameter int CNT_W = 16);
  logic             req_valid;
  logic             req_ready;
  logic             branch;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;
  logic             resp_valid;
  logic             taken;
  logic             illegal;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush;
  logic             busy;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;
  modport master (
    output req_valid, branch, funct3, rs1_val, rs2_val, pc, imm,
    input  req_ready, resp_valid, taken, illegal, redirect_valid, redirect_pc,
           flush, busy, branch_cnt, taken_cnt
  );
  modport slave (
    input  req_valid, branch, funct3, rs1_val, rs2_val, pc, imm,
    output req_ready, resp_valid, taken, illegal, redirect_valid, redirect_pc,
           flush, busy, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer: multi-cycle branch resolution with redirect, flush window and saturating counters
module branch_sequencer #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic              clk,
  input logic              reset,
  branch_sequencer_if.slave bus
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, CMP, RESOLVE, FLUSH} state_t;
  state_t           state, state_n;
  logic             br_q;
  logic [2:0]       f3_q;
  logic [XLEN-1:0]  a_q, b_q, pc_q, imm_q, tgt_q, redir_q;
  logic             n_q, z_q, c_q, v_q;
  logic [FW-1:0]    fcnt;
  logic [CNT_W-1:0] bcnt, tcnt;
  logic [XLEN:0]    sum;
  logic [XLEN-1:0]  diff;
  logic             acc, res, ill, base, tk;
  // subtraction as a + ~b + 1 so the carry-out is the unsigned a >= b flag
  assign sum  = {1'b0, a_q} + {1'b0, ~b_q} + {{XLEN{1'b0}}, 1'b1};
  assign diff = sum[XLEN-1:0];
  assign acc  = bus.req_valid & (state == IDLE);
  assign res  = state == RESOLVE;
  always_comb begin
    ill     = br_q & (f3_q[2:1] == 2'b01);
    base    = f3_q[2] ? (f3_q[1] ? ~c_q : (n_q ^ v_q)) : z_q;
    tk      = ~br_q | (~ill & (base ^ f3_q[0]));
    state_n = state == IDLE    ? (acc ? CMP : IDLE) :
              state == CMP     ? RESOLVE :
              state == RESOLVE ? (tk ? FLUSH : IDLE) :
              (fcnt == FW'(1) ? IDLE : FLUSH);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      br_q    <= 1'b0;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      tgt_q   <= '0;
      redir_q <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      fcnt    <= '0;
      bcnt    <= '0;
      tcnt    <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        br_q  <= bus.branch;
        f3_q  <= bus.funct3;
        a_q   <= bus.rs1_val;
        b_q   <= bus.rs2_val;
        pc_q  <= bus.pc;
        imm_q <= bus.imm;
      end
      if (state == CMP) begin
        n_q   <= diff[XLEN-1];
        z_q   <= diff == '0;
        c_q   <= sum[XLEN];
        v_q   <= (a_q[XLEN-1] != b_q[XLEN-1]) && (diff[XLEN-1] != a_q[XLEN-1]);
        tgt_q <= pc_q + imm_q;
      end
      if (res) begin
        bcnt <= &bcnt ? bcnt : bcnt + 1'b1;
        tcnt <= (tk & ~&tcnt) ? tcnt + 1'b1 : tcnt;
        fcnt <= FW'(FLUSH_CYCLES);
        if (tk) redir_q <= tgt_q;
      end
      if (state == FLUSH) fcnt <= fcnt - 1'b1;
    end
  end
  assign bus.req_ready      = state == IDLE;
  assign bus.busy           = state != IDLE;
  assign bus.resp_valid     = res;
  assign bus.taken          = res & tk;
  assign bus.illegal        = res & ill;
  assign bus.redirect_valid = res & tk;
  assign bus.redirect_pc    = (res & tk) ? tgt_q : redir_q;
  assign bus.flush          = state == FLUSH;
  assign bus.branch_cnt     = bcnt;
  assign bus.taken_cnt      = tcnt;
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: randomized scoreboard bench for branch_sequencer with a behavioural branch model
module tb_branch_sequencer;
  localparam int XLEN = 32;
  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  branch_sequencer_if #(.XLEN(XLEN), .CNT_W(CW)) bus();
  branch_sequencer #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  typedef struct {
    logic        tk;
    logic        ill;
    logic [31:0] tgt;
  } exp_t;
  exp_t        q[$];
  exp_t        e;
  int          passed = 0;
  int          total = 0;
  int          bc = 0;
  int          tc = 0;
  int          exp_flush = 0;
  logic [31:0] last_tgt = '0;
  time         t_prev = 0;
  logic        prev_tk = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t model(logic br, logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] p, logic [31:0] i);
    exp_t r;
    r.tgt = p + i;
    r.ill = 1'b0;
    if (!br) r.tk = 1'b1;
    else case (f3)
      3'd0: r.tk = a == b;
      3'd1: r.tk = a != b;
      3'd4: r.tk = $signed(a) <  $signed(b);
      3'd5: r.tk = $signed(a) >= $signed(b);
      3'd6: r.tk = a <  b;
      3'd7: r.tk = a >= b;
      default: begin r.tk = 1'b0; r.ill = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic send(logic br, logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                      logic [31:0] p, logic [31:0] i);
    exp_t x = model(br, f3, a, b, p, i);
    logic chained = bus.req_valid;
    int n = 0;
    time t;
    @(negedge clk);
    bus.branch = br; bus.funct3 = f3; bus.rs1_val = a; bus.rs2_val = b; bus.pc = p; bus.imm = i;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      chk("accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    t = $time;
    q.push_back(x);
    if (chained) chk("accept_gap", (t - t_prev) / 10, prev_tk ? 3 + FC : 3);
    t_prev = t;
    prev_tk = x.tk;
    #1;
    // later input changes must not disturb the latched request
    bus.rs1_val = $urandom; bus.rs2_val = $urandom; bus.pc = $urandom; bus.imm = $urandom;
    bus.branch = 1'($urandom); bus.funct3 = 3'($urandom);
  endtask

  task automatic idle(int n);
    bus.req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    bus.req_valid = 1'b0;
    reset = 1'b1;
    q.delete();
    bc = 0; tc = 0; last_tgt = '0; exp_flush = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", {bus.req_ready, bus.busy, bus.flush, bus.resp_valid, bus.redirect_valid,
                     bus.taken, bus.illegal}, 7'b1000000);
    chk("rst_cnt", {bus.branch_cnt, bus.taken_cnt}, '0);
    chk("rst_pc", bus.redirect_pc, '0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("flush", bus.flush, exp_flush > 0);
      if (exp_flush > 0) exp_flush--;
      chk("busy", bus.busy, !bus.req_ready);
      if (bus.resp_valid) begin
        if (q.size() == 0) chk("unexpected_resp", 1, 0);
        else begin
          e = q.pop_front();
          chk("taken", bus.taken, e.tk);
          chk("illegal", bus.illegal, e.ill);
          chk("redirect_valid", bus.redirect_valid, e.tk);
          chk("redirect_pc", bus.redirect_pc, e.tk ? e.tgt : last_tgt);
          chk("counters", {bus.branch_cnt, bus.taken_cnt}, {CW'(bc), CW'(tc)});
          bc = bc < MAXC ? bc + 1 : bc;
          tc = (e.tk && tc < MAXC) ? tc + 1 : tc;
          if (e.tk) begin last_tgt = e.tgt; exp_flush = FC; end
        end
      end else begin
        chk("quiet", {bus.taken, bus.illegal, bus.redirect_valid}, '0);
        chk("redirect_hold", bus.redirect_pc, last_tgt);
      end
    end
  end

  initial begin
    logic [31:0] a;
    int n;
    bus.req_valid = 1'b0; bus.branch = 1'b0; bus.funct3 = '0;
    bus.rs1_val = '0; bus.rs2_val = '0; bus.pc = '0; bus.imm = '0;
    do_reset();
    send(1, 3'b000, 32'h5, 32'h5, 32'h100, 32'h20);
    send(1, 3'b000, 32'h1, 32'h2, 32'h0, 32'h4);
    idle(4);
    send(1, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h8);
    send(1, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h8);
    send(1, 3'b101, 32'h8000_0000, 32'h1, 32'h400, 32'h8);
    idle(5);
    send(0, 3'b001, 32'h7, 32'h7, 32'hFFFF_FFF0, 32'h20);
    idle(5);
    send(1, 3'b010, 32'h3, 32'h3, 32'h500, 32'h10);
    send(1, 3'b011, 32'h3, 32'h4, 32'h500, 32'h10);
    for (int k = 0; k < 4; k++) send(1, 3'b001, 32'h9, 32'h9, 32'h600, 32'h4);
    idle(4);
    send(1, 3'b000, 32'h1, 32'h1, 32'h700, 32'h40);
    do_reset();
    send(0, 3'b000, 32'h0, 32'h0, 32'h800, 32'h40);
    idle(2);
    do_reset();
    for (int k = 0; k < 17; k++) send(0, 3'($urandom), $urandom, $urandom, $urandom, $urandom);
    idle(8);
    chk("sat_cnt", {bus.branch_cnt, bus.taken_cnt}, {CW'(MAXC), CW'(MAXC)});
    for (int k = 0; k < 200; k++) begin
      a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
      send($urandom_range(0, 3) != 0, 3'($urandom), a,
           $urandom_range(0, 2) == 0 ? a : ($urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom),
           $urandom, $urandom);
      if ($urandom_range(0, 49) == 0) do_reset();
      else if ($urandom_range(0, 4) == 0) idle($urandom_range(0, 6));
    end
    idle(0);
    n = 0;
    while ((q.size() != 0 || !bus.req_ready) && n < 20) begin @(negedge clk); n++; end
    chk("drain", q.size(), 0);
    @(negedge clk);
    chk("final_cnt", {bus.branch_cnt, bus.taken_cnt}, {CW'(bc), CW'(tc)});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
Multi-cycle branch resolution controller between the decode stage and the fetch PC mux. Per request it registers operands, generates the N/Z/C/V compare flags, applies the RISC-V funct3 branch condition, and computes the target. On a taken outcome it issues a one-cycle redirect followed by a programmable flush window. Saturating branch and taken counters feed the performance registers.

Parameters:
XLEN, 32, operand / PC / immediate width
FLUSH_CYCLES, 2, cycles flush is held after a taken redirect (must be >= 1)
CNT_W, 16, width of branch_cnt and taken_cnt

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  sequencer can accept a request
Branch  in  1  1 = conditional branch; 0 = unconditional jump (always taken)
funct3  in  3  branch condition code
rs1_val  in  XLEN  operand A
rs2_val  in  XLEN  operand B
pc  in  XLEN  PC of the branch
imm  in  XLEN  sign-extended offset
resp_valid  out  1  one-cycle pulse: outcome valid
taken  out  1  outcome, qualified by resp_valid
illegal  out  1  pulse with resp_valid for undefined funct3
redirect_valid  out  1  one-cycle pulse: load redirect_pc
redirect_pc  out  XLEN  pc + imm
flush  out  1  squash younger instructions
busy  out  1  high in every non-IDLE state
branch_cnt  out  CNT_W  resolved requests, saturating
taken_cnt  out  CNT_W  taken outcomes, saturating

Behaviour:
- Reset (synchronous, active-high): state IDLE; every output 0 except req_ready = 1; counters 0; all latched fields 0. Reset asserted in any state aborts the operation, with no resp/redirect/flush pulses in the reset cycle or afterwards.
- Handshake: a request is accepted when req_valid & req_ready at a clk edge. req_ready = (state == IDLE). Inputs are latched at acceptance; later input changes are ignored.
- FSM states: IDLE -> CMP -> RESOLVE -> (FLUSH | IDLE).
- IDLE: wait for acceptance; on acceptance go to CMP.
- CMP, one cycle: register diff = rs1 - rs2 (XLEN bits, computed as rs1 + ~rs2 + 1).
  - N = diff[XLEN-1]
  - Z = (diff == 0)
  - C = carry-out (1 iff rs1 >= rs2 unsigned)
  - V = signed overflow of the subtraction
  - Register tgt = pc + imm, modulo 2^XLEN with no overflow flag.
- RESOLVE, one cycle: resp_valid = 1.
  - If Branch = 0: taken = 1.
  - Otherwise by funct3:
    - 000: taken = Z
    - 001: taken = ~Z
    - 100: taken = (N != V)
    - 101: taken = (N == V)
    - 110: taken = ~C
    - 111: taken = C
    - 010/011: taken = 0 and illegal = 1
  - If taken: redirect_valid = 1, redirect_pc = tgt, next state FLUSH. Otherwise next state IDLE.
- Counters update in RESOLVE: branch_cnt += 1; taken_cnt += taken. Both saturate at all-ones with no wrap.
- FLUSH: flush = 1 for exactly FLUSH_CYCLES cycles, using an internal down-counter loaded in RESOLVE. When the count expires, go to IDLE.
- redirect_pc holds its value until the next taken RESOLVE. taken and illegal are 0 outside RESOLVE.
- Latency: accept at edge 0; resp_valid is high in cycle 2. The next request can be accepted in cycle 3 if not taken, or in cycle 3 + FLUSH_CYCLES if taken.
- A req_valid held high during busy is not accepted and not lost; the requester keeps it asserted.

Test Plan:
- Scenario 1: BEQ, Branch=1, funct3=000, rs1=rs2=0x0000_0005, pc=0x100, imm=0x20 -> resp_valid in cycle 2, taken=1, redirect_pc=0x120, flush high for 2 cycles, req_ready returns in cycle 5; branch_cnt=1, taken_cnt=1.
- Scenario 2: signed vs unsigned, rs1=0xFFFF_FFFF, rs2=0x0000_0001:
  - BLT (100) -> taken=1
  - BLTU (110) -> taken=0, no redirect, no flush
  - BGE with rs1=0x8000_0000, rs2=0x0000_0001 (V=1) -> taken=0
- Scenario 3: Branch=0, funct3=001, rs1=rs2 -> taken=1 (jump); pc=0xFFFF_FFF0, imm=0x20 -> redirect_pc=0x0000_0010 (wrap).
- Scenario 4: funct3=010 -> illegal=1, taken=0, returns to IDLE. Back-to-back not-taken requests with req_valid held high -> one accept every 3 cycles.
- Scenario 5: reset asserted in CMP, and separately in the 1st FLUSH cycle -> next cycle IDLE, flush=0, resp_valid=0, counters=0, req_ready=1.
- Scenario 6: CNT_W=4, 17 taken branches -> branch_cnt=taken_cnt=0xF, with no wrap.
